output_sink_mc: RTL and testbench

OUTPUT_SINK_MC -- requirements
Module: output_sink_mc

---
 rtl/output_sink_mc.sv | 170 +++++++++++++++++
 tb/tb_output_sink_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_sink_mc.sv
// Output sink: an input FIFO feeding either a master stream (MODE=1) or an
// internal drain (MODE=0). Popped beats are summed per packet. Completed
// packets are counted per destination channel and in total.

// Saturating completed-packet counter for one destination channel.
module output_sink_mc_chcnt #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            inc_i,
  output logic [CNTW-1:0] cnt_o
);
  logic [CNTW-1:0] cnt_q;

  // Count completed packets and hold at all-ones.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)                   cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

  assign cnt_o = cnt_q;
endmodule

module output_sink_mc #(
  parameter int          TDATAW      = 32,
  parameter int          TDESTW      = 4,
  parameter int          TIDW        = 2,
  parameter int          DEPTH       = 4,
  parameter int          NUM_CH      = 4,
  parameter int          MODE        = 0,
  parameter int unsigned EXPECT_PKTS = 1,
  parameter int          CNTW        = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   AXIS_S_TVALID,
  output logic                   AXIS_S_TREADY,
  input  logic [TDATAW-1:0]      AXIS_S_TDATA,
  input  logic                   AXIS_S_TLAST,
  input  logic [TIDW-1:0]        AXIS_S_TID,
  input  logic [TDESTW-1:0]      AXIS_S_TDEST,
  output logic                   AXIS_M_TVALID,
  input  logic                   AXIS_M_TREADY,
  output logic [TDATAW-1:0]      AXIS_M_TDATA,
  output logic                   AXIS_M_TLAST,
  output logic [TIDW-1:0]        AXIS_M_TID,
  output logic [TDESTW-1:0]      AXIS_M_TDEST,
  output logic [NUM_CH*CNTW-1:0] PKT_CNT,
  output logic [TDATAW-1:0]      PKT_SUM,
  output logic                   SUM_VALID,
  output logic                   ERR_DEST,
  output logic                   DONE
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [TDESTW:0] NCH_L   = (TDESTW+1)'(NUM_CH);

  typedef struct packed {
    logic [TDATAW-1:0] data;
    logic              last;
    logic [TIDW-1:0]   id;
    logic [TDESTW-1:0] dest;
  } beat_t;

  typedef enum logic {IDLE, ACTIVE} st_t;

  beat_t       mem_q [DEPTH];
  beat_t       head;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   occ_q;
  logic          rdy_q;
  logic          full, empty, push, pop, dest_ok, fin;
  st_t           state_q, state_d;
  logic [TDATAW-1:0] acc_q, acc_d, sum_w, pkt_sum_q;
  logic          sum_valid_q, err_q, done_q;
  logic [CNTW-1:0] tot_q, tot_d;
  logic [NUM_CH-1:0][CNTW-1:0] pkt_cnt;
  logic          unused_ok;

  assign full          = (occ_q == DEPTH_L);
  assign empty         = (occ_q == '0);
  assign AXIS_S_TREADY = rdy_q && !full;
  assign push          = AXIS_S_TVALID && AXIS_S_TREADY;
  assign pop           = !empty && ((MODE == 0) || AXIS_M_TREADY);
  assign head          = mem_q[rd_q];
  assign dest_ok       = ({1'b0, head.dest} < NCH_L);
  assign fin           = pop && head.last;

  // Beat storage; contents are don't-care until occupancy covers them.
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= '{data: AXIS_S_TDATA, last: AXIS_S_TLAST,
                               id: AXIS_S_TID, dest: AXIS_S_TDEST};

  // Pointers and occupancy; rdy_q keeps TREADY low until reset has released.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wr_q <= '0; rd_q <= '0; occ_q <= '0; rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end

  generate
    if (MODE == 1) begin : g_fwd
      assign AXIS_M_TVALID = !empty;
      assign AXIS_M_TDATA  = head.data;
      assign AXIS_M_TLAST  = head.last;
      assign AXIS_M_TID    = head.id;
      assign AXIS_M_TDEST  = head.dest;
      assign unused_ok     = 1'b0;
    end else begin : g_sink
      assign AXIS_M_TVALID = 1'b0;
      assign AXIS_M_TDATA  = '0;
      assign AXIS_M_TLAST  = 1'b0;
      assign AXIS_M_TID    = '0;
      assign AXIS_M_TDEST  = '0;
      assign unused_ok     = AXIS_M_TREADY ^ (^head.id);
    end
  endgenerate

  // Accumulator FSM: only a pop advances it; the last beat closes the packet.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_w   = ((state_q == ACTIVE) ? acc_q : '0) + head.data;
    tot_d   = tot_q;
    if (pop) begin
      if (head.last) begin
        state_d = IDLE;
        acc_d   = '0;
        if (tot_q != '1) tot_d = tot_q + 1'b1;
      end else begin
        state_d = ACTIVE;
        acc_d   = sum_w;
      end
    end
  end

  // Packet sum, status flags and total count.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE; acc_q <= '0; pkt_sum_q <= '0; sum_valid_q <= 1'b0;
      err_q <= 1'b0; tot_q <= '0; done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tot_q       <= tot_d;
      sum_valid_q <= fin;
      if (fin)             pkt_sum_q <= sum_w;
      if (pop && !dest_ok) err_q     <= 1'b1;
      done_q <= done_q || (32'(tot_d) >= EXPECT_PKTS);
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    output_sink_mc_chcnt #(.CNTW(CNTW)) u_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .inc_i (fin && dest_ok && (head.dest == TDESTW'(c))),
      .cnt_o (pkt_cnt[c])
    );
  end

  assign PKT_CNT   = pkt_cnt;
  assign PKT_SUM   = pkt_sum_q;
  assign SUM_VALID = sum_valid_q;
  assign ERR_DEST  = err_q;
  assign DONE      = done_q;
endmodule

// File: tb/tb_output_sink_mc.sv
// Bench for output_sink_mc: a terminal-sink instance (8-bit data, 2-bit
// counters) driven with directed packets, and a forwarding instance checked
// against a stream-level model of beats, packet sums and counts.
module tb_output_sink_mc;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic rst_n;

  // dut0: MODE=0, TDATAW=8, CNTW=2
  logic s0_vld, s0_rdy, s0_last, m0_vld, m0_rdy, m0_last, sv0, err0, done0;
  logic [7:0] s0_data, m0_data, sum0;
  logic [1:0] s0_id, m0_id;
  logic [3:0] s0_dest, m0_dest;
  logic [7:0] cnt0;

  // dut1: MODE=1, TDATAW=32, CNTW=16, EXPECT_PKTS=8
  logic s1_vld, s1_rdy, s1_last, m1_vld, m1_rdy, m1_last, sv1, err1, done1;
  logic [31:0] s1_data, m1_data, sum1;
  logic [1:0] s1_id, m1_id;
  logic [3:0] s1_dest, m1_dest;
  logic [63:0] cnt1;

  output_sink_mc #(.TDATAW(8), .MODE(0), .EXPECT_PKTS(1), .CNTW(2)) dut0 (
    .CLK(CLK), .RST_N(rst_n),
    .AXIS_S_TVALID(s0_vld), .AXIS_S_TREADY(s0_rdy), .AXIS_S_TDATA(s0_data),
    .AXIS_S_TLAST(s0_last), .AXIS_S_TID(s0_id), .AXIS_S_TDEST(s0_dest),
    .AXIS_M_TVALID(m0_vld), .AXIS_M_TREADY(m0_rdy), .AXIS_M_TDATA(m0_data),
    .AXIS_M_TLAST(m0_last), .AXIS_M_TID(m0_id), .AXIS_M_TDEST(m0_dest),
    .PKT_CNT(cnt0), .PKT_SUM(sum0), .SUM_VALID(sv0), .ERR_DEST(err0), .DONE(done0));

  output_sink_mc #(.TDATAW(32), .MODE(1), .EXPECT_PKTS(8), .CNTW(16)) dut1 (
    .CLK(CLK), .RST_N(rst_n),
    .AXIS_S_TVALID(s1_vld), .AXIS_S_TREADY(s1_rdy), .AXIS_S_TDATA(s1_data),
    .AXIS_S_TLAST(s1_last), .AXIS_S_TID(s1_id), .AXIS_S_TDEST(s1_dest),
    .AXIS_M_TVALID(m1_vld), .AXIS_M_TREADY(m1_rdy), .AXIS_M_TDATA(m1_data),
    .AXIS_M_TLAST(m1_last), .AXIS_M_TID(m1_id), .AXIS_M_TDEST(m1_dest),
    .PKT_CNT(cnt1), .PKT_SUM(sum1), .SUM_VALID(sv1), .ERR_DEST(err1), .DONE(done1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // dut0 sum pulse monitor
  int pulses0 = 0;
  logic [7:0] last_sum0 = '0;
  always @(negedge CLK) if (sv0) begin pulses0++; last_sum0 = sum0; end

  // dut1 reference model: expected beat order, packet sums, channel counts
  typedef struct {
    logic [31:0] d; logic l; logic [1:0] id; logic [3:0] dst;
  } bt_t;
  bt_t         expq[$];
  logic [31:0] sumq[$];
  bt_t         e;
  logic [31:0] cur = '0;
  int          mcnt[4] = '{0, 0, 0, 0};
  int          mtot = 0, accepted1 = 0, delivered1 = 0;
  logic        merr = 1'b0;

  always @(negedge CLK) if (rst_n) begin
    if (m1_vld && m1_rdy) begin
      delivered1++;
      if (expq.size() == 0) chk("m1_spurious", 64'(m1_vld), 64'd0);
      else begin
        e = expq.pop_front();
        chk("m1_beat", {m1_data, m1_last, m1_id, m1_dest}, {e.d, e.l, e.id, e.dst});
      end
    end
    if (sv1) begin
      if (sumq.size() == 0) chk("sum1_spurious", 64'(sv1), 64'd0);
      else chk("pkt_sum1", 64'(sum1), 64'(sumq.pop_front()));
    end
    if (s1_vld && s1_rdy) begin
      accepted1++;
      expq.push_back('{d: s1_data, l: s1_last, id: s1_id, dst: s1_dest});
      cur = cur + s1_data;
      if (s1_dest >= 4) merr = 1'b1;
      if (s1_last) begin
        sumq.push_back(cur);
        cur = '0;
        mtot++;
        if (s1_dest < 4 && mcnt[s1_dest] < 65535) mcnt[s1_dest]++;
      end
    end
  end

  task automatic send0(input logic [7:0] d, input logic l, input logic [3:0] dst);
    bit fire;
    int t = 0;
    s0_vld = 1'b1; s0_data = d; s0_last = l; s0_dest = dst; s0_id = 2'($urandom);
    do begin
      @(negedge CLK); fire = s0_rdy;
      @(posedge CLK); #1; t++;
    end while (!fire && t < 50);
    if (!fire) chk("send0_timeout", 64'(s0_rdy), 64'd1);
    s0_vld = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d, input logic l, input logic [3:0] dst);
    bit fire;
    int t = 0;
    s1_vld = 1'b1; s1_data = d; s1_last = l; s1_dest = dst; s1_id = 2'($urandom);
    do begin
      @(negedge CLK); fire = s1_rdy;
      @(posedge CLK); #1; t++;
    end while (!fire && t < 100);
    if (!fire) chk("send1_timeout", 64'(s1_rdy), 64'd1);
    s1_vld = 1'b0;
  endtask

  // Random traffic on dut1; a stalled beat is held until accepted.
  task automatic run1(input int ncyc, input int pv, input int pr);
    bit fire;
    int t = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK); fire = s1_vld && s1_rdy;
      @(posedge CLK); #1;
      if (fire || !s1_vld) begin
        s1_vld  = (int'($urandom_range(99)) < pv);
        s1_data = $urandom;
        s1_last = ($urandom_range(2) == 0);
        s1_id   = 2'($urandom);
        s1_dest = 4'($urandom_range(4));
      end
      m1_rdy = (int'($urandom_range(99)) < pr);
    end
    m1_rdy = 1'b1;
    while (s1_vld && t < 100) begin
      @(negedge CLK); fire = s1_rdy;
      @(posedge CLK); #1; t++;
      if (fire) s1_vld = 1'b0;
    end
    if (s1_vld) chk("run1_timeout", 64'(s1_rdy), 64'd1);
    s1_vld = 1'b0;
  endtask

  initial begin
    int a0, d0, k, t, both;
    bit fire;
    rst_n = 1'b0;
    s0_vld = 0; s0_data = 0; s0_last = 0; s0_id = 0; s0_dest = 0; m0_rdy = 0;
    s1_vld = 0; s1_data = 0; s1_last = 0; s1_id = 0; s1_dest = 0; m1_rdy = 0;
    #22;
    chk("rst_s0_rdy", 64'(s0_rdy), 0);
    chk("rst_s1_rdy", 64'(s1_rdy), 0);
    chk("rst_m1_vld", 64'(m1_vld), 0);
    chk("rst_outs0", {cnt0, sum0, sv0, err0, done0}, 0);
    chk("rst_outs1", {sum1, sv1, err1, done1}, 0);
    chk("rst_cnt1", cnt1, 0);
    #5 rst_n = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // three-beat packet, drained internally
    a0 = pulses0;
    send0(8'h10, 0, 1); send0(8'h20, 0, 1); send0(8'h30, 1, 1);
    repeat (3) @(posedge CLK); #1;
    chk("p3_pulses", 64'(pulses0 - a0), 1);
    chk("p3_sum", 64'(last_sum0), 64'h60);
    chk("p3_cnt1", 64'(cnt0[2+:2]), 1);
    chk("p3_done", 64'(done0), 1);
    chk("p3_m0_idle", {m0_vld, m0_data, m0_last, m0_id, m0_dest}, 0);

    // modulo wrap of 8-bit sum
    send0(8'hF0, 0, 0); send0(8'h20, 1, 0);
    repeat (3) @(posedge CLK); #1;
    chk("wrap_sum", 64'(sum0), 64'h10);
    chk("wrap_cnt0", 64'(cnt0[0+:2]), 1);

    // out-of-range destination
    chk("err0_pre", 64'(err0), 0);
    send0(8'h03, 1, 5);
    repeat (3) @(posedge CLK); #1;
    chk("err0_set", 64'(err0), 1);
    chk("err0_cnt", 64'(cnt0), 64'h05);
    chk("err0_sum", 64'(sum0), 64'h03);

    // saturation of 2-bit counters
    for (int i = 0; i < 5; i++) send0(8'(i + 1), 1, 0);
    repeat (3) @(posedge CLK); #1;
    chk("sat_cnt0", 64'(cnt0[0+:2]), 3);
    chk("err0_sticky", 64'(err0), 1);

    // backpressure: 6 beats offered, 4 fit
    m1_rdy = 1'b0; a0 = accepted1; d0 = delivered1; k = 0;
    s1_vld = 1; s1_data = 32'hA000; s1_last = 0; s1_id = 0; s1_dest = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK); fire = s1_vld && s1_rdy;
      @(posedge CLK); #1;
      if (fire) begin
        k++;
        if (k < 6) begin s1_data = 32'hA000 + 32'(k); s1_last = (k == 5); end
        else s1_vld = 0;
      end
    end
    chk("bp_accepted", 64'(accepted1 - a0), 4);
    chk("bp_s1_rdy", 64'(s1_rdy), 0);
    chk("bp_head", {m1_vld, m1_data}, {1'b1, 32'hA000});
    m1_rdy = 1'b1; t = 0;
    while (k < 6 && t < 40) begin
      @(negedge CLK); fire = s1_vld && s1_rdy;
      @(posedge CLK); #1; t++;
      if (fire) begin
        k++;
        if (k < 6) begin s1_data = 32'hA000 + 32'(k); s1_last = (k == 5); end
        else s1_vld = 0;
      end
    end
    repeat (6) @(posedge CLK); #1;
    chk("bp_delivered", 64'(delivered1 - d0), 6);

    // out-of-range destination still forwarded
    chk("err1_pre", 64'(err1), 0);
    d0 = delivered1;
    send1(32'h55, 1, 5);
    repeat (4) @(posedge CLK); #1;
    chk("err1_set", 64'(err1), 1);
    chk("err1_fwd", 64'(delivered1 - d0), 1);
    chk("err1_cnt", 64'(cnt1[16+:16]), 64'(mcnt[1]));

    // simultaneous push/pop every cycle
    both = 0;
    s1_vld = 1; s1_data = $urandom; s1_last = $urandom_range(1); s1_dest = 4'($urandom_range(3));
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i > 0 && s1_rdy && m1_vld && m1_rdy) both++;
      @(posedge CLK); #1;
      s1_data = $urandom; s1_last = $urandom_range(1); s1_dest = 4'($urandom_range(3));
    end
    s1_vld = 0;
    chk("tput_both", 64'(both), 19);

    // random traffic against the model
    run1(500, 70, 60);
    send1(32'h1234_5678, 1, 2);
    repeat (10) @(posedge CLK); #1;
    chk("end_expq", 64'(expq.size()), 0);
    chk("end_sumq", 64'(sumq.size()), 0);
    for (int c = 0; c < 4; c++) chk($sformatf("end_cnt1_%0d", c), 64'(cnt1[c*16+:16]), 64'(mcnt[c]));
    chk("end_err1", 64'(err1), 64'(merr));
    chk("end_done1", 64'(done1), 64'(mtot >= 8));

    // reset in the middle of a packet
    send0(8'h01, 0, 2); send0(8'h02, 0, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_s0", {s0_rdy, cnt0, sum0, sv0, err0, done0}, 0);
    chk("mid_rst_s1", {s1_rdy, m1_vld, sum1, sv1, err1, done1}, 0);
    chk("mid_rst_cnt1", cnt1, 0);
    @(negedge CLK); rst_n = 1'b1;
    repeat (2) @(posedge CLK); #1;
    send0(8'h07, 1, 2);
    repeat (3) @(posedge CLK); #1;
    chk("post_rst_sum", 64'(sum0), 64'h07);
    chk("post_rst_cnt2", 64'(cnt0[4+:2]), 1);
    chk("post_rst_done", 64'(done0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
